// File: rtl/uart_tx.sv
// UART transmitter on the shared 16x oversampled clock: 8 data bits MSB first, 1 or 2 stop bits.
// Optional even parity bit when UART_TX_PARITY_EN is defined; the default build sends 8N1/8N2.
module uart_tx #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clkx16,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned SC_W   = 4;
  localparam int unsigned BI_W   = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(15);
  localparam logic [BI_W-1:0] BI_MSB  = BI_W'(DATA_W - 1);
  localparam logic            LAST_SI = 1'(STOP_BITS - 1);

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [SC_W-1:0]     sc_q, sc_d;
  logic [BI_W-1:0]     bi_q, bi_d;
  logic                si_q, si_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                tx_d, busy_d, done_d;

  // State, counters and all outputs are registered; reset forces the line idle at once.
  always_ff @(posedge clkx16 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      si_q    <= 1'b0;
      sh_q    <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      si_q    <= si_d;
      sh_q    <= sh_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic; tx_d is the value for the upcoming bit so tx changes right on the boundary.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bi_d    = bi_q;
    si_d    = si_q;
    sh_d    = sh_q;
    tx_d    = tx;
    busy_d  = busy;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        sc_d   = '0;
        if (send) begin
          sh_d    = data;
          sc_d    = '0;
          state_d = START;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end

      START: begin
        sc_d = sc_q + SC_W'(1);
        if (sc_q == SC_LAST) begin
          bi_d    = BI_MSB;
          tx_d    = sh_q[BI_MSB];
          state_d = DATA;
        end
      end

      DATA: begin
        sc_d = sc_q + SC_W'(1);
        if (sc_q == SC_LAST) begin
          if (bi_q != '0) begin
            bi_d = bi_q - BI_W'(1);
            tx_d = sh_q[bi_d];
          end else begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^sh_q;
`else
            state_d = STOP;
            si_d    = 1'b0;
            tx_d    = 1'b1;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        sc_d = sc_q + SC_W'(1);
        if (sc_q == SC_LAST) begin
          state_d = STOP;
          si_d    = 1'b0;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        sc_d = sc_q + SC_W'(1);
        tx_d = 1'b1;
        if (sc_q == SC_LAST) begin
          if (si_q == LAST_SI) begin
            state_d = IDLE;
            si_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            si_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sc_d    = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle frame checks plus a mid-bit sampling receiver model.
// Define UART_TX_PARITY_EN for both files to exercise the parity build.
module tb_uart_tx;

  localparam int unsigned SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 16 * (9 + PB + SB);

  logic       clkx16 = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] data   = 8'h00;
  logic       send   = 1'b0;
  logic       tx;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  uart_tx #(.STOP_BITS(SB)) dut (
    .clkx16(clkx16),
    .reset (reset),
    .data  (data),
    .send  (send),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clkx16 = ~clkx16;
  always @(posedge clkx16) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level for 16-cycle segment s of a frame carrying d.
  function automatic logic seg_exp(input logic [7:0] d, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return d[3'(8 - s)];
    if ((PB == 1) && (s == 9)) return ^d;
    return 1'b1;
  endfunction

  // Receiver model: detect start, sample mid-bit, collect bytes and start times.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;
  int         rx_start = 0;
  int         rx_err  = 0;
  logic [7:0] rx_sh   = 8'h00;

  always @(negedge clkx16) begin
    if (reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy  = 1'b1;
        rx_cnt   = 0;
        rx_start = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 8) begin
        if (tx !== 1'b0) rx_err++;
      end else if ((rx_cnt >= 24) && (rx_cnt <= 136) && (rx_cnt % 16 == 8)) begin
        rx_sh = {rx_sh[6:0], tx};
      end else if ((PB == 1) && (rx_cnt == 152)) begin
        if (tx !== ^rx_sh) rx_err++;
      end else if ((rx_cnt >= 16 * (9 + PB) + 8) && (rx_cnt % 16 == 8)) begin
        if (tx !== 1'b1) rx_err++;
        if (rx_cnt == 16 * (9 + PB + SB - 1) + 8) begin
          rx_q.push_back(rx_sh);
          rx_t.push_back(rx_start);
          rx_busy = 1'b0;
        end
      end
    end
  end

  // Request d, then check every cycle of the frame and the first idle cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input int inj_at,
                           input logic [7:0] inj_d, input bit hold);
    int bad;
    bad  = 0;
    send = 1'b1;
    data = d;
    @(negedge clkx16);
    for (int j = 0; j < FRAME; j++) begin
      if ((tx !== seg_exp(d, j / 16)) || (busy !== 1'b1) || (done !== 1'b0)) bad++;
      if (j % 16 == 8)
        check($sformatf("%s seg%0d", tag, j / 16), 32'(tx), 32'(seg_exp(d, j / 16)));
      send = hold || (j == inj_at);
      if (j == inj_at) data = inj_d;
      @(negedge clkx16);
    end
    check({tag, " bad_samples"}, bad, 0);
    check({tag, " end_busy"}, 32'(busy), 0);
    check({tag, " end_done"}, 32'(done), 1);
    check({tag, " end_tx"}, 32'(tx), 1);
  endtask

  initial begin
    int bad;

    repeat (3) @(negedge clkx16);
    check("rst tx", 32'(tx), 1);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clkx16);
      if ((tx !== 1'b1) || (busy !== 1'b0) || (done !== 1'b0)) bad++;
    end
    check("idle100 bad", bad, 0);

    // Single frame 0xA5
    rx_q.delete(); rx_t.delete();
    run_frame("a5", 8'hA5, -1, 8'h00, 1'b0);
    @(negedge clkx16);
    check("a5 done_clear", 32'(done), 0);
    check("a5 rx_count", rx_q.size(), 1);
    check("a5 rx_data", 32'(rx_q[0]), 32'h A5);

    // Request while busy is dropped
    rx_q.delete(); rx_t.delete();
    run_frame("3c", 8'h3C, 40, 8'hFF, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge clkx16);
      if ((done === 1'b1) || (busy !== 1'b0) || (tx !== 1'b1)) bad++;
    end
    check("3c quiet_after", bad, 0);
    check("3c rx_count", rx_q.size(), 1);
    check("3c rx_data", 32'(rx_q[0]), 32'h3C);

    // send held high: back-to-back frames, data change mid-frame ignored
    rx_q.delete(); rx_t.delete();
    run_frame("h00", 8'h00, 5, 8'hFF, 1'b1);
    run_frame("hff", 8'hFF, -1, 8'h00, 1'b1);
    send = 1'b0;
    repeat (20) @(negedge clkx16);
    check("hold rx_count", rx_q.size(), 2);
    check("hold rx_data0", 32'(rx_q[0]), 32'h00);
    check("hold rx_data1", 32'(rx_q[1]), 32'hFF);
    check("hold period", rx_t[1] - rx_t[0], FRAME + 1);
    check("hold busy_after", 32'(busy), 0);

    // Reset mid-frame
    rx_q.delete(); rx_t.delete();
    send = 1'b1;
    data = 8'h81;
    @(negedge clkx16);
    send = 1'b0;
    repeat (69) @(negedge clkx16);
    check("81 pre_reset_tx", 32'(tx), 0);
    check("81 pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("81 reset_tx", 32'(tx), 1);
    check("81 reset_busy", 32'(busy), 0);
    check("81 reset_done", 32'(done), 0);
    repeat (2) @(negedge clkx16);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clkx16);
      if ((done === 1'b1) || (busy !== 1'b0) || (tx !== 1'b1)) bad++;
    end
    check("81 no_done", bad, 0);
    run_frame("42", 8'h42, -1, 8'h00, 1'b0);
    repeat (4) @(negedge clkx16);
    check("42 rx_count", rx_q.size(), 1);
    check("42 rx_data", 32'(rx_q[0]), 32'h42);

`ifdef UART_TX_PARITY_EN
    rx_q.delete(); rx_t.delete();
    run_frame("p07", 8'h07, -1, 8'h00, 1'b0);
    run_frame("p03", 8'h03, -1, 8'h00, 1'b0);
    repeat (4) @(negedge clkx16);
    check("par rx_count", rx_q.size(), 2);
    check("par frame_len", FRAME, 176);
`endif

    check("rx_err", rx_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
